cache_mem_arbiter: RTL and testbench

- Shares the single memory/bus port between the Icache and Dcache miss/write paths.
- Accepts Icache line-read requests and Dcache line-read or single-word write-through requests, serialises them onto one mem port, and routes each handshake back to the granted cache.
- Dcache has priority; a starvation counter guarantees Icache forward progress.
- Sits between the L1 caches and the AXI bridge.

---
 rtl/cache_mem_arbiter_pkg.sv | 41 ++++
 rtl/cache_mem_arb_sel.sv | 80 ++++++++
 rtl/cache_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared encodings and helpers for the cache memory arbiter
//
// Purpose: FSM state encoding, owner encoding, transfer size codes and the
//          line-width derivation shared by cache_mem_arbiter and cache_mem_arb_sel.
// Ports:   none (package).
package cache_mem_arbiter_pkg;

  // 3-bit state codes
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_I_ADDR  = 3'd1;
  localparam logic [2:0] ST_I_DATA  = 3'd2;
  localparam logic [2:0] ST_D_ADDR  = 3'd3;
  localparam logic [2:0] ST_D_RDATA = 3'd4;
  localparam logic [2:0] ST_D_WRESP = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_I_ADDR  = ST_I_ADDR,
    S_I_DATA  = ST_I_DATA,
    S_D_ADDR  = ST_D_ADDR,
    S_D_RDATA = ST_D_RDATA,
    S_D_WRESP = ST_D_WRESP
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

  // Memory transfer size codes
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Cache line width in bits for a given log2(words per line)
  function automatic int line_width(input int offset_width);
    return 32 * (1 << offset_width);
  endfunction

endpackage

// File: rtl/cache_mem_arb_sel.sv
// rtl/cache_mem_arb_sel.sv - owner-based request mux and handshake demux
//
// Purpose: drives the shared memory request fields from whichever cache owns
//          the port and routes addrOK/dataOK/bvalid back to that owner only.
// Ports:   i_owner / i_*_phase   - current owner and transaction phase
//          i_icache_* / i_dcache_* - requester fields
//          i_mem_*               - memory handshakes
//          o_mem_*               - shared memory request fields
//          o_icache_* / o_dcache_* - per-cache handshake pulses
module cache_mem_arb_sel
  import cache_mem_arbiter_pkg::*;
(
  input  arb_owner_t  i_owner,
  input  logic        i_addr_phase,
  input  logic        i_rdata_phase,
  input  logic        i_wresp_phase,
  input  logic [31:0] i_icache_addr,
  input  logic        i_dcache_wr,
  input  logic [1:0]  i_dcache_size,
  input  logic [3:0]  i_dcache_wstrb,
  input  logic [31:0] i_dcache_addr,
  input  logic [31:0] i_dcache_wdata,
  input  logic        i_mem_addr_ok,
  input  logic        i_mem_data_ok,
  input  logic        i_mem_bvalid,
  output logic        o_mem_req,
  output logic        o_mem_wr,
  output logic [1:0]  o_mem_size,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_icache_addr_ok,
  output logic        o_icache_data_ok,
  output logic        o_dcache_addr_ok,
  output logic        o_dcache_data_ok,
  output logic        o_dcache_bvalid
);

  logic w_is_i;
  logic w_is_d;

  assign w_is_i = (i_owner == OWN_I);
  assign w_is_d = (i_owner == OWN_D);

  // Fields are only presented during the address phase; everything is 0 otherwise
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_size  = 2'd0;
    o_mem_wstrb = 4'd0;
    o_mem_addr  = 32'd0;
    o_mem_wdata = 32'd0;
    if (i_addr_phase) begin
      case (i_owner)
        OWN_I: begin
          o_mem_req  = 1'b1;
          o_mem_size = SIZE_W;
          o_mem_addr = i_icache_addr;
        end
        OWN_D: begin
          o_mem_req   = 1'b1;
          o_mem_wr    = i_dcache_wr;
          o_mem_size  = i_dcache_size;
          o_mem_wstrb = i_dcache_wstrb;
          o_mem_addr  = i_dcache_addr;
          o_mem_wdata = i_dcache_wdata;
        end
        default: ;
      endcase
    end
  end

  // Responses outside the matching phase are dropped here, never forwarded
  assign o_icache_addr_ok = w_is_i && i_addr_phase  && i_mem_addr_ok;
  assign o_icache_data_ok = w_is_i && i_rdata_phase && i_mem_data_ok;
  assign o_dcache_addr_ok = w_is_d && i_addr_phase  && i_mem_addr_ok;
  assign o_dcache_data_ok = w_is_d && i_rdata_phase && i_mem_data_ok;
  assign o_dcache_bvalid  = w_is_d && i_wresp_phase && i_mem_bvalid;

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - Icache/Dcache arbiter onto a single memory port
//
// Purpose: serialises Icache line reads and Dcache line reads / word writes
//          onto one memory port. Dcache wins by default; after starve_limit
//          consecutive Dcache grants with an Icache request waiting, Icache wins.
// Ports:   clk, rstn (sync, active-high)
//          icache_mem_* / mem_icache_* - Icache request and handshakes
//          dcache_mem_* / mem_dcache_* - Dcache request and handshakes
//          arb_mem_* / mem_arb_*       - shared memory port
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int offset_width = 2,
  parameter int starve_limit = 4,
  localparam int LW = line_width(offset_width)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          icache_mem_req,
  input  logic [31:0]   icache_mem_addr,
  output logic          mem_icache_addrOK,
  output logic          mem_icache_dataOK,
  output logic [LW-1:0] mem_icache_data,
  input  logic          dcache_mem_req,
  input  logic          dcache_mem_wr,
  input  logic [1:0]    dcache_mem_size,
  input  logic [3:0]    dcache_mem_wstrb,
  input  logic [31:0]   dcache_mem_addr,
  input  logic [31:0]   dcache_mem_wdata,
  output logic          mem_dcache_addrOK,
  output logic          mem_dcache_dataOK,
  output logic          mem_dcache_bvalid,
  output logic [LW-1:0] mem_dcache_data,
  output logic          arb_mem_req,
  output logic          arb_mem_wr,
  output logic [1:0]    arb_mem_size,
  output logic [3:0]    arb_mem_wstrb,
  output logic [31:0]   arb_mem_addr,
  output logic [31:0]   arb_mem_wdata,
  input  logic          mem_arb_addrOK,
  input  logic          mem_arb_dataOK,
  input  logic          mem_arb_bvalid,
  input  logic [LW-1:0] mem_arb_data
);

  localparam int CW = $clog2(starve_limit + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(starve_limit);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic [CW-1:0] r_starve_cnt;

  logic       w_starved;
  logic       w_grant_d;
  logic       w_grant_i;
  arb_owner_t w_owner;
  logic       w_addr_phase;
  logic       w_rdata_phase;
  logic       w_wresp_phase;

  // Icache overrides Dcache priority only once the counter has saturated
  assign w_starved = icache_mem_req && (r_starve_cnt == STARVE_MAX);
  assign w_grant_d = dcache_mem_req && !w_starved;
  assign w_grant_i = icache_mem_req && !w_grant_d;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (!icache_mem_req || w_grant_i) begin
          r_starve_cnt <= '0;
        end else if (w_grant_d && (r_starve_cnt != STARVE_MAX)) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = S_D_ADDR;
        end else if (w_grant_i) begin
          w_state_nxt = S_I_ADDR;
        end
      end
      S_I_ADDR:   if (mem_arb_addrOK) w_state_nxt = S_I_DATA;
      S_I_DATA:   if (mem_arb_dataOK) w_state_nxt = S_IDLE;
      S_D_ADDR:   if (mem_arb_addrOK) w_state_nxt = dcache_mem_wr ? S_D_WRESP : S_D_RDATA;
      S_D_RDATA:  if (mem_arb_dataOK) w_state_nxt = S_IDLE;
      S_D_WRESP:  if (mem_arb_bvalid) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Owner and phase are pure decodes of the state, so IDLE means no owner
  always_comb begin
    w_owner       = OWN_NONE;
    w_addr_phase  = 1'b0;
    w_rdata_phase = 1'b0;
    w_wresp_phase = 1'b0;
    case (r_state)
      S_I_ADDR:  begin w_owner = OWN_I; w_addr_phase  = 1'b1; end
      S_I_DATA:  begin w_owner = OWN_I; w_rdata_phase = 1'b1; end
      S_D_ADDR:  begin w_owner = OWN_D; w_addr_phase  = 1'b1; end
      S_D_RDATA: begin w_owner = OWN_D; w_rdata_phase = 1'b1; end
      S_D_WRESP: begin w_owner = OWN_D; w_wresp_phase = 1'b1; end
      default: ;
    endcase
  end

  cache_mem_arb_sel u_sel (
    .i_owner          (w_owner),
    .i_addr_phase     (w_addr_phase),
    .i_rdata_phase    (w_rdata_phase),
    .i_wresp_phase    (w_wresp_phase),
    .i_icache_addr    (icache_mem_addr),
    .i_dcache_wr      (dcache_mem_wr),
    .i_dcache_size    (dcache_mem_size),
    .i_dcache_wstrb   (dcache_mem_wstrb),
    .i_dcache_addr    (dcache_mem_addr),
    .i_dcache_wdata   (dcache_mem_wdata),
    .i_mem_addr_ok    (mem_arb_addrOK),
    .i_mem_data_ok    (mem_arb_dataOK),
    .i_mem_bvalid     (mem_arb_bvalid),
    .o_mem_req        (arb_mem_req),
    .o_mem_wr         (arb_mem_wr),
    .o_mem_size       (arb_mem_size),
    .o_mem_wstrb      (arb_mem_wstrb),
    .o_mem_addr       (arb_mem_addr),
    .o_mem_wdata      (arb_mem_wdata),
    .o_icache_addr_ok (mem_icache_addrOK),
    .o_icache_data_ok (mem_icache_dataOK),
    .o_dcache_addr_ok (mem_dcache_addrOK),
    .o_dcache_data_ok (mem_dcache_dataOK),
    .o_dcache_bvalid  (mem_dcache_bvalid)
  );

  // The line is shared; only the owner's dataOK qualifies it
  assign mem_icache_data = mem_arb_data;
  assign mem_dcache_data = mem_arb_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
  localparam int OW = 2;
  localparam int SL = 4;
  localparam int LW = 32 * (1 << OW);

  typedef struct packed {
    logic          d;
    logic          wr;
    logic [1:0]    size;
    logic [3:0]    wstrb;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [LW-1:0] line;
  } req_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          icache_mem_req = 1'b0;
  logic [31:0]   icache_mem_addr = 32'h0;
  logic          mem_icache_addrOK, mem_icache_dataOK;
  logic [LW-1:0] mem_icache_data;
  logic          dcache_mem_req = 1'b0;
  logic          dcache_mem_wr = 1'b0;
  logic [1:0]    dcache_mem_size = 2'd0;
  logic [3:0]    dcache_mem_wstrb = 4'd0;
  logic [31:0]   dcache_mem_addr = 32'h0;
  logic [31:0]   dcache_mem_wdata = 32'h0;
  logic          mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_bvalid;
  logic [LW-1:0] mem_dcache_data;
  logic          arb_mem_req, arb_mem_wr;
  logic [1:0]    arb_mem_size;
  logic [3:0]    arb_mem_wstrb;
  logic [31:0]   arb_mem_addr, arb_mem_wdata;
  logic          mem_arb_addrOK = 1'b0;
  logic          mem_arb_dataOK = 1'b0;
  logic          mem_arb_bvalid = 1'b0;
  logic [LW-1:0] mem_arb_data = '0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.offset_width(OW), .starve_limit(SL)) dut (
    .clk(clk), .rstn(rstn),
    .icache_mem_req(icache_mem_req), .icache_mem_addr(icache_mem_addr),
    .mem_icache_addrOK(mem_icache_addrOK), .mem_icache_dataOK(mem_icache_dataOK),
    .mem_icache_data(mem_icache_data),
    .dcache_mem_req(dcache_mem_req), .dcache_mem_wr(dcache_mem_wr),
    .dcache_mem_size(dcache_mem_size), .dcache_mem_wstrb(dcache_mem_wstrb),
    .dcache_mem_addr(dcache_mem_addr), .dcache_mem_wdata(dcache_mem_wdata),
    .mem_dcache_addrOK(mem_dcache_addrOK), .mem_dcache_dataOK(mem_dcache_dataOK),
    .mem_dcache_bvalid(mem_dcache_bvalid), .mem_dcache_data(mem_dcache_data),
    .arb_mem_req(arb_mem_req), .arb_mem_wr(arb_mem_wr), .arb_mem_size(arb_mem_size),
    .arb_mem_wstrb(arb_mem_wstrb), .arb_mem_addr(arb_mem_addr), .arb_mem_wdata(arb_mem_wdata),
    .mem_arb_addrOK(mem_arb_addrOK), .mem_arb_dataOK(mem_arb_dataOK),
    .mem_arb_bvalid(mem_arb_bvalid), .mem_arb_data(mem_arb_data)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  req_t iq[$];
  req_t dq[$];
  req_t exp_q[$];
  req_t m_cur = '0;
  int   m_phase = 0;
  int   m_cnt = 0;
  int   addr_lat = 1;
  int   data_lat = 1;
  bit   spur = 1'b0;
  bit   b2b = 1'b0;
  int   cyc = 0;
  int   last_d_aok = -1;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [76:0] ctl_outs();
    return {mem_icache_addrOK, mem_icache_dataOK, mem_dcache_addrOK, mem_dcache_dataOK,
            mem_dcache_bvalid, arb_mem_req, arb_mem_wr, arb_mem_size, arb_mem_wstrb,
            arb_mem_addr, arb_mem_wdata};
  endfunction

  function automatic req_t mk_i(input logic [31:0] a, input logic [LW-1:0] ln);
    req_t r;
    r = '0;
    r.size = 2'd2;
    r.addr = a;
    r.line = ln;
    return r;
  endfunction

  function automatic req_t mk_d(input logic wr, input logic [1:0] sz, input logic [3:0] st,
                                input logic [31:0] a, input logic [31:0] wd, input logic [LW-1:0] ln);
    req_t r;
    r.d = 1'b1; r.wr = wr; r.size = sz; r.wstrb = st; r.addr = a; r.wdata = wd;
    r.line = wr ? '0 : ln;
    return r;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic apply_reqs();
    icache_mem_req  = (iq.size() != 0);
    icache_mem_addr = (iq.size() != 0) ? iq[0].addr : 32'h0;
    dcache_mem_req  = (dq.size() != 0);
    if (dq.size() != 0) begin
      dcache_mem_wr = dq[0].wr; dcache_mem_size = dq[0].size; dcache_mem_wstrb = dq[0].wstrb;
      dcache_mem_addr = dq[0].addr; dcache_mem_wdata = dq[0].wdata;
    end else begin
      dcache_mem_wr = 1'b0; dcache_mem_size = 2'd0; dcache_mem_wstrb = 4'd0;
      dcache_mem_addr = 32'h0; dcache_mem_wdata = 32'h0;
    end
  endtask

  // One clock: drive requesters and memory model after the edge, check at negedge
  task automatic tick();
    logic [4:0] hs_exp;
    logic [4:0] hs_act;
    bit accept;
    bit spur_now;
    @(posedge clk); #1;
    cyc++;
    apply_reqs();
    mem_arb_addrOK = 1'b0; mem_arb_dataOK = 1'b0; mem_arb_bvalid = 1'b0; mem_arb_data = '0;
    hs_exp = 5'b0; accept = 1'b0; spur_now = 1'b0;
    if (m_phase == 0 && arb_mem_req) begin
      m_phase = 1; m_cnt = addr_lat;
    end
    if (m_phase == 1) begin
      if (m_cnt == 0) begin
        mem_arb_addrOK = 1'b1; accept = 1'b1; m_phase = 2; m_cnt = data_lat;
        if (exp_q.size() != 0) m_cur = exp_q.pop_front();
        else begin check("exp_underflow", 1, 0); m_cur = '0; end
        hs_exp = m_cur.d ? 5'b00100 : 5'b10000;
      end else begin
        m_cnt--;
        if (spur) begin mem_arb_dataOK = 1'b1; mem_arb_bvalid = 1'b1; spur_now = 1'b1; end
      end
    end else if (m_phase == 2) begin
      m_cnt--;
      if (m_cnt <= 0) begin
        m_phase = 0;
        if (m_cur.wr) begin mem_arb_bvalid = 1'b1; hs_exp = 5'b00001; end
        else begin
          mem_arb_dataOK = 1'b1; mem_arb_data = m_cur.line;
          hs_exp = m_cur.d ? 5'b00010 : 5'b01000;
        end
      end else if (spur) begin
        spur_now = 1'b1;
        if (m_cur.wr) mem_arb_dataOK = 1'b1; else mem_arb_bvalid = 1'b1;
      end
    end
    @(negedge clk);
    hs_act = {mem_icache_addrOK, mem_icache_dataOK, mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_bvalid};
    if (hs_exp != 0 || hs_act != 0 || spur_now) check("handshake", hs_act, hs_exp);
    if (accept) begin
      check("mem_req", arb_mem_req, 1);
      check("mem_wr", arb_mem_wr, m_cur.wr);
      check("mem_size", arb_mem_size, m_cur.size);
      check("mem_wstrb", arb_mem_wstrb, m_cur.wstrb);
      check("mem_addr", arb_mem_addr, m_cur.addr);
      check("mem_wdata", arb_mem_wdata, m_cur.wdata);
    end
    if (hs_exp[3]) check("i_line", mem_icache_data, m_cur.line);
    if (hs_exp[1]) check("d_line", mem_dcache_data, m_cur.line);
    if (mem_icache_addrOK) begin
      check("starve_clr", dut.r_starve_cnt, 0);
      if (iq.size() != 0) void'(iq.pop_front());
    end
    if (mem_dcache_addrOK) begin
      if (b2b && last_d_aok >= 0) check("b2b_gap", cyc - last_d_aok, 3);
      last_d_aok = cyc;
      if (dq.size() != 0) void'(dq.pop_front());
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || iq.size() != 0 || dq.size() != 0 || m_phase != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", (exp_q.size() == 0 && m_phase == 0), 1);
    tick();
    check("back_idle", dut.r_state, 0);
  endtask

  initial begin
    req_t r;
    logic [LW-1:0] ln;

    repeat (3) tick();
    check("rst_ctl", ctl_outs(), 0);
    check("rst_idata", mem_icache_data, 0);
    check("rst_state", dut.r_state, 0);
    check("rst_starve", dut.r_starve_cnt, 0);
    rstn = 1'b0;

    // Icache line read
    addr_lat = 1; data_lat = 3; spur = 1'b0;
    ln = {(LW / 32){32'hDEADBEEF}};
    iq.push_back(mk_i(32'h1C000040, ln)); exp_q.push_back(mk_i(32'h1C000040, ln));
    tick(); check("i_lat_n", arb_mem_req, 0);
    tick(); check("i_lat_n1", arb_mem_req, 1);
    drain(100);

    // Dcache write-through with stray responses
    addr_lat = 1; data_lat = 3; spur = 1'b1;
    r = mk_d(1'b1, 2'd0, 4'b0010, 32'h00001004, 32'h12345678, '0);
    dq.push_back(r); exp_q.push_back(r);
    drain(100);
    spur = 1'b0;

    // Starvation: held I + D requests -> D, D, D, D, I, D
    addr_lat = 1; data_lat = 2;
    ln = rnd_line();
    iq.push_back(mk_i(32'h20000000, ln));
    for (int k = 0; k < 5; k++) begin
      r = mk_d(1'b0, 2'd2, 4'hF, 32'h00004000 + 32'(k * 16), 32'h0, rnd_line());
      dq.push_back(r);
      exp_q.push_back(r);
      if (k == 3) exp_q.push_back(mk_i(32'h20000000, ln));
    end
    drain(300);
    check("starve_end", dut.r_starve_cnt, 0);

    // Back-to-back Dcache reads, zero-latency memory
    addr_lat = 0; data_lat = 1; b2b = 1'b1; last_d_aok = -1;
    for (int k = 0; k < 3; k++) begin
      r = mk_d(1'b0, 2'd2, 4'hF, 32'h00008000 + 32'(k * 16), 32'h0, rnd_line());
      dq.push_back(r); exp_q.push_back(r);
    end
    drain(100);
    b2b = 1'b0;

    // Reset while an Icache read waits for data
    addr_lat = 0; data_lat = 20;
    ln = {(LW / 32){32'hA5A50F0F}};
    iq.push_back(mk_i(32'h00003000, ln)); exp_q.push_back(mk_i(32'h00003000, ln));
    repeat (3) tick();
    m_phase = 0;
    r = mk_d(1'b0, 2'd2, 4'hF, 32'h0000C000, 32'h0, rnd_line());
    dq.push_back(r); exp_q.push_back(r);
    rstn = 1'b1;
    tick();
    check("rst_mid_ctl", ctl_outs(), 0);
    check("rst_mid_data", mem_icache_data, 0);
    check("rst_mid_state", dut.r_state, 0);
    rstn = 1'b0;
    data_lat = 2;
    drain(100);

    // Early dataOK during D_ADDR must be ignored
    addr_lat = 3; data_lat = 2; spur = 1'b1;
    r = mk_d(1'b0, 2'd2, 4'hF, 32'h0000D000, 32'h0, rnd_line());
    dq.push_back(r); exp_q.push_back(r);
    drain(100);
    spur = 1'b0;

    // Random single transactions
    for (int k = 0; k < 8; k++) begin
      addr_lat = $urandom_range(0, 2);
      data_lat = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        r = mk_d(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 4'($urandom), $urandom, $urandom, rnd_line());
        dq.push_back(r);
      end else begin
        r = mk_i($urandom & 32'hFFFF_FFF0, rnd_line());
        iq.push_back(r);
      end
      exp_q.push_back(r);
      drain(100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
